outgoing_ar_queue: RTL and testbench
====================================

Name: outgoing_ar_queue

Overview:
Parametrised AR request queue between ar_ordering_unit and the AXI slave; next generation of the 8-entry outgoing AR FIFO. Adds an optional empty-queue bypass, a programmable almost-full flag, a level output, and a read-outstanding limiter. The limiter holds issue to the slave while MAX_OUTSTANDING bursts are in flight, counted from issued AR to completed R burst.

Parameters:
ID_WIDTH, 32, AR id width
ADDR_WIDTH, 32, AR address width
LEN_WIDTH, 8, AR len width
SIZE_WIDTH, 3, AR size width
BURST_WIDTH, 2, AR burst width
QOS_WIDTH, 4, AR qos width
DEPTH, 8, entries (>=2, need not be a power of two)
BYPASS, 0, 1 = fall-through when empty, 0 = always stored first
AF_THRESH, 6, almost_full asserts when level >= AF_THRESH (1..DEPTH)
MAX_OUTSTANDING, 16, in-flight burst limit; 0 = unlimited

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
ar_in  ar_if.receiver  -  requests from ar_ordering_unit (valid, ready, id, addr, len, size, burst, qos)
ar_out  ar_if.sender  -  requests to AXI slave
rsp_done  in  1  one-cycle pulse per completed read burst (slave R valid & ready & last)
level  out  CNT_W=$clog2(DEPTH+1)  stored entry count
almost_full  out  1  level >= AF_THRESH
outstanding  out  OUT_W=max(1,$clog2(MAX_OUTSTANDING+1))  issued, uncompleted bursts
underflow_err  out  1  sticky: rsp_done seen while outstanding == 0

Behaviour:
- Reset (rst_n low, asynchronous, any time): pointers, level, outstanding and underflow_err go to 0. Stored entries are discarded. ar_out.valid = 0, ar_in.ready = 0 while rst_n is low, almost_full = 0. Payload contents are not reset.
- ar_in.ready = ~full (full: level == DEPTH). Push = ar_in.valid & ar_in.ready & ~bypass_take.
- throttle = (MAX_OUTSTANDING != 0) & (outstanding == MAX_OUTSTANDING).
- Stored path: ar_out.valid = ~empty & ~throttle. Payload is the head entry. Pop = ar_out.valid & ar_out.ready.
- Bypass path (BYPASS=1 and level == 0): ar_out.valid = ar_in.valid & ~throttle. Payload is ar_in, combinational.
  - bypass_take = ar_in.valid & ar_out.valid & ar_out.ready. The request passes in the same cycle and is not stored.
  - If the slave is not ready, the request is pushed and the head path applies from the next cycle.
  - The payload is unchanged, because upstream holds AXI-stable.
- Latency: BYPASS=0 gives one cycle from push to ar_out.valid. BYPASS=1 on an empty queue gives zero cycles.
- ar_out payload is zero whenever ar_out.valid = 0.
- AXI stability: once ar_out.valid is high it stays high with a stable payload until the handshake.
  - Guaranteed because outstanding only increments on an ar_out handshake, so throttle can only deassert while waiting.
  - An assertion checks this.
- Level: +1 on push only, -1 on pop only, unchanged on both or neither.
  - Push while full cannot occur (ready = 0).
  - Push and pop together at full is not possible, since push needs ready.
  - Push and pop together at level 1 leaves level at 1 and moves the head.
- Pointers wrap explicitly from DEPTH-1 to 0.
- Outstanding: +1 on ar_out handshake (stored or bypass), -1 on rsp_done, unchanged if both fire.
  - rsp_done at 0 leaves the count at 0 and sets underflow_err, held until reset.
  - With MAX_OUTSTANDING = 0 the counter still counts, saturating at its maximum, and never throttles.
- almost_full and level are registered-state derived (combinational from level_q). No combinational path from ar_out.ready to ar_in.ready.

Decomposition:
- Shared package ar_buf_pkg:
  - default width constants (ID/ADDR/LEN/SIZE/BURST/QOS)
  - a ptr_width(depth) function returning max(1,$clog2(depth))
- ar_entry_t struct is declared locally in the module from the width parameters.
- One sub-module, rd_outstanding_tracker: up/down counter with limit, throttle output and underflow_err. It is reused later on the write side.

Test Plan:
- BYPASS=0, ready=1: push id=3 addr=0x1000 at cycle 0 -> ar_out.valid at cycle 1 with id=3, addr=0x1000; level back to 0 at cycle 2.
- Slave ready=0, push 8 requests (id 0..7) -> level=8, ar_in.ready=0, almost_full high from level 6. Then ready=1 -> ids 0..7 out in order, a pointer wrap is exercised, level returns to 0.
- BYPASS=1, empty, ready=1, ar_in id=5 -> ar_out.valid and id=5 in the same cycle; level stays 0.
  - With ready=0 -> stored, level=1, valid held with id=5 until the handshake.
- MAX_OUTSTANDING=2, 4 queued, ready=1, no rsp_done -> 2 issued, outstanding=2, ar_out.valid=0, level=2. One rsp_done pulse -> next request issues, outstanding stays 2.
- rsp_done with outstanding=0 -> underflow_err=1, sticky until rst_n low, outstanding stays 0.
- Assert rst_n low mid-stream with level=4 and outstanding=3 -> all outputs 0 asynchronously. After release, the first new push appears with no stale entries.

Source files
------------

// File: rtl/ar_buf_pkg.sv
// rtl/ar_buf_pkg.sv - shared width defaults and pointer sizing for the AR request buffers
package ar_buf_pkg;
    localparam int DEF_ID_WIDTH    = 32;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_LEN_WIDTH   = 8;
    localparam int DEF_SIZE_WIDTH  = 3;
    localparam int DEF_BURST_WIDTH = 2;
    localparam int DEF_QOS_WIDTH   = 4;

    function automatic int ptr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction
endpackage

// File: rtl/ar_if.sv
// rtl/ar_if.sv - AXI read-address channel bundle
interface ar_if
    import ar_buf_pkg::*;
#(
    parameter int ID_WIDTH    = DEF_ID_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
    parameter int SIZE_WIDTH  = DEF_SIZE_WIDTH,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH,
    parameter int QOS_WIDTH   = DEF_QOS_WIDTH
);
    logic                   valid;
    logic                   ready;
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
    logic [QOS_WIDTH-1:0]   qos;

    modport sender (output valid, output id, output addr, output len, output size,
                    output burst, output qos, input ready);
    modport receiver (input valid, input id, input addr, input len, input size,
                      input burst, input qos, output ready);
endinterface

// File: rtl/rd_outstanding_tracker.sv
// rtl/rd_outstanding_tracker.sv - in-flight burst counter with issue limit and sticky underflow
module rd_outstanding_tracker #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int OUT_W           = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic             done,
    output logic [OUT_W-1:0] count,
    output logic             throttle,
    output logic             underflow_err
);
    // Unlimited mode still counts, but saturates at the counter's all-ones value.
    localparam logic [OUT_W-1:0] CNT_MAX =
        (MAX_OUTSTANDING == 0) ? {OUT_W{1'b1}} : OUT_W'(MAX_OUTSTANDING);

    logic [OUT_W-1:0] count_q;
    logic             underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (done && count_q == '0) underflow_q <= 1'b1;
            if (issue && !done && count_q != CNT_MAX) begin
                count_q <= count_q + 1'b1;
            end else if (done && !issue && count_q != '0) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign count         = count_q;
    assign throttle      = (MAX_OUTSTANDING != 0) && (count_q == CNT_MAX);
    assign underflow_err = underflow_q;
endmodule

// File: rtl/outgoing_ar_queue.sv
// rtl/outgoing_ar_queue.sv - AR request queue with optional bypass, almost-full, level and read limiter
module outgoing_ar_queue
    import ar_buf_pkg::*;
#(
    parameter int ID_WIDTH        = DEF_ID_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH       = DEF_LEN_WIDTH,
    parameter int SIZE_WIDTH      = DEF_SIZE_WIDTH,
    parameter int BURST_WIDTH     = DEF_BURST_WIDTH,
    parameter int QOS_WIDTH       = DEF_QOS_WIDTH,
    parameter int DEPTH           = 8,
    parameter int BYPASS          = 0,
    parameter int AF_THRESH       = 6,
    parameter int MAX_OUTSTANDING = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int OUT_W = (MAX_OUTSTANDING < 1) ? 1 : $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    ar_if.receiver           ar_in,
    ar_if.sender             ar_out,
    input  logic             rsp_done,
    output logic [CNT_W-1:0] level,
    output logic             almost_full,
    output logic [OUT_W-1:0] outstanding,
    output logic             underflow_err
);
    localparam int PTR_W = ptr_width(DEPTH);

    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [LEN_WIDTH-1:0]   len;
        logic [SIZE_WIDTH-1:0]  size;
        logic [BURST_WIDTH-1:0] burst;
        logic [QOS_WIDTH-1:0]   qos;
    } ar_entry_t;

    ar_entry_t        mem [DEPTH];
    ar_entry_t        in_ent;
    ar_entry_t        out_ent;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] level_q;
    logic             full;
    logic             empty;
    logic             throttle;
    logic             bypass_mode;
    logic             out_valid;
    logic             handshake;
    logic             bypass_take;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ent = '{id: ar_in.id, addr: ar_in.addr, len: ar_in.len, size: ar_in.size,
                      burst: ar_in.burst, qos: ar_in.qos};

    assign full        = (level_q == CNT_W'(DEPTH));
    assign empty       = (level_q == '0);
    assign bypass_mode = (BYPASS != 0) && empty;
    // Gated by rst_n so the bypass path cannot present a request while held in reset.
    assign out_valid   = rst_n && !throttle && (bypass_mode ? ar_in.valid : !empty);
    assign handshake   = out_valid && ar_out.ready;
    assign bypass_take = bypass_mode && handshake;
    assign ar_in.ready = rst_n && !full;
    assign push        = ar_in.valid && ar_in.ready && !bypass_take;
    assign pop         = handshake && !bypass_mode;
    assign out_ent     = out_valid ? (bypass_mode ? in_ent : mem[rd_ptr]) : '0;

    assign ar_out.valid = out_valid;
    assign ar_out.id    = out_ent.id;
    assign ar_out.addr  = out_ent.addr;
    assign ar_out.len   = out_ent.len;
    assign ar_out.size  = out_ent.size;
    assign ar_out.burst = out_ent.burst;
    assign ar_out.qos   = out_ent.qos;

    assign level       = level_q;
    assign almost_full = (level_q >= CNT_W'(AF_THRESH));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_ent;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
        end
    end

    rd_outstanding_tracker #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .OUT_W          (OUT_W)
    ) u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue        (handshake),
        .done         (rsp_done),
        .count        (outstanding),
        .throttle     (throttle),
        .underflow_err(underflow_err)
    );

    ar_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !ar_out.ready) |=> (out_valid && $stable(out_ent)));
endmodule

// File: tb/tb_outgoing_ar_queue.sv
// tb/tb_outgoing_ar_queue.sv - bench for outgoing_ar_queue (stored/limited and bypass/unlimited builds)
module tb_outgoing_ar_queue;
    typedef struct packed {
        logic [31:0] id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  qos;
    } ent_t;

    typedef struct packed {
        logic       in_ready;
        logic       out_valid;
        ent_t       ent;
        logic [3:0] level;
        logic       af;
        logic [4:0] outst;
        logic       uf;
    } obs_t;

    typedef struct {
        logic        in_valid;
        logic [31:0] id;
        logic [31:0] addr;
        logic        out_ready;
        logic        rsp;
        logic        exp_valid;
        logic [31:0] exp_id;
        logic [31:0] exp_addr;
        int          exp_level;
        int          exp_outst;
    } vec_t;

    // dut0: stored path, depth 8, limit 2; dut1: bypass, depth 5, unlimited
    localparam int P_DEPTH [2] = '{8, 5};
    localparam int P_BYP   [2] = '{0, 1};
    localparam int P_AF    [2] = '{6, 3};
    localparam int P_MAX   [2] = '{2, 0};
    localparam int P_SAT   [2] = '{3, 1};

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid [2];
    ent_t in_ent [2];
    logic out_ready [2];
    logic rsp [2];
    logic [3:0] level0;
    logic [2:0] level1;
    logic af0, af1, uf0, uf1;
    logic [1:0] outst0;
    logic [0:0] outst1;
    obs_t obs [2];

    ent_t mq [2][$];
    int   mout [2];
    bit   muf [2];
    bit   macc [2];
    obs_t exp_now [2];
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ar_if in0 (), out0 (), in1 (), out1 ();

    assign in0.valid = in_valid[0];
    assign in0.id    = in_ent[0].id;
    assign in0.addr  = in_ent[0].addr;
    assign in0.len   = in_ent[0].len;
    assign in0.size  = in_ent[0].size;
    assign in0.burst = in_ent[0].burst;
    assign in0.qos   = in_ent[0].qos;
    assign out0.ready = out_ready[0];
    assign in1.valid = in_valid[1];
    assign in1.id    = in_ent[1].id;
    assign in1.addr  = in_ent[1].addr;
    assign in1.len   = in_ent[1].len;
    assign in1.size  = in_ent[1].size;
    assign in1.burst = in_ent[1].burst;
    assign in1.qos   = in_ent[1].qos;
    assign out1.ready = out_ready[1];

    outgoing_ar_queue #(.DEPTH(8), .BYPASS(0), .AF_THRESH(6), .MAX_OUTSTANDING(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .ar_in(in0), .ar_out(out0), .rsp_done(rsp[0]),
        .level(level0), .almost_full(af0), .outstanding(outst0), .underflow_err(uf0));

    outgoing_ar_queue #(.DEPTH(5), .BYPASS(1), .AF_THRESH(3), .MAX_OUTSTANDING(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .ar_in(in1), .ar_out(out1), .rsp_done(rsp[1]),
        .level(level1), .almost_full(af1), .outstanding(outst1), .underflow_err(uf1));

    assign obs[0] = {in0.ready, out0.valid, out0.id, out0.addr, out0.len, out0.size,
                     out0.burst, out0.qos, level0, af0, {3'b0, outst0}, uf0};
    assign obs[1] = {in1.ready, out1.valid, out1.id, out1.addr, out1.len, out1.size,
                     out1.burst, out1.qos, {1'b0, level1}, af1, {4'b0, outst1}, uf1};

    function automatic obs_t model_obs(int k);
        obs_t o;
        int   lvl;
        bit   thr, byp;
        o   = '0;
        lvl = mq[k].size();
        if (rst_n) begin
            thr = (P_MAX[k] != 0) && (mout[k] == P_MAX[k]);
            byp = (P_BYP[k] != 0) && (lvl == 0);
            o.in_ready  = (lvl != P_DEPTH[k]);
            o.out_valid = byp ? (in_valid[k] && !thr) : (lvl > 0 && !thr);
            if (o.out_valid) o.ent = byp ? in_ent[k] : mq[k][0];
        end
        o.level = 4'(lvl);
        o.af    = (lvl >= P_AF[k]);
        o.outst = 5'(mout[k]);
        o.uf    = muf[k];
        return o;
    endfunction

    task automatic model_step(int k, obs_t e);
        bit hs, byp, take, push, pop;
        int cap;
        macc[k] = 1'b0;
        if (!rst_n) return;
        hs   = e.out_valid && out_ready[k];
        byp  = (P_BYP[k] != 0) && (mq[k].size() == 0);
        take = byp && hs;
        push = in_valid[k] && e.in_ready && !take;
        pop  = hs && !byp;
        macc[k] = push || take;
        if (pop)  void'(mq[k].pop_front());
        if (push) mq[k].push_back(in_ent[k]);
        cap = (P_MAX[k] != 0) ? P_MAX[k] : P_SAT[k];
        if (rsp[k] && mout[k] == 0) muf[k] = 1'b1;
        if (hs && !rsp[k]) mout[k] = (mout[k] < cap) ? mout[k] + 1 : cap;
        else if (rsp[k] && !hs && mout[k] > 0) mout[k] = mout[k] - 1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mout[k] = 0;
            muf[k]  = 1'b0;
            macc[k] = 1'b0;
        end
    endtask

    task automatic chk(string name, logic [127:0] got, logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Called at posedge+1; compares every output of both instances at the falling edge.
    task automatic sample();
        #4;
        for (int k = 0; k < 2; k++) begin
            exp_now[k] = model_obs(k);
            n_tests++;
            if (obs[k] !== exp_now[k]) begin
                n_fail++;
                $display("FAIL model dut%0d t=%0t: got %0h want %0h", k, $time, obs[k], exp_now[k]);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, exp_now[k]);
        #1;
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_ent[k] = '0; out_ready[k] = 1'b0; rsp[k] = 1'b0;
        end
    endtask

    function automatic ent_t mk(logic [31:0] id, logic [31:0] addr);
        ent_t e;
        e = '0; e.id = id; e.addr = addr; e.len = 8'(id + 1); e.size = 3'd2; e.burst = 2'd1;
        return e;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.id = $urandom(); e.addr = $urandom(); e.len = 8'($urandom());
        e.size = 3'($urandom()); e.burst = 2'($urandom()); e.qos = 4'($urandom());
        return e;
    endfunction

    vec_t vecs [4];

    initial begin
        vecs[0] = '{1'b1, 32'd3, 32'h1000, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0,    0, 0};
        vecs[1] = '{1'b0, 32'd0, 32'h0,    1'b1, 1'b0, 1'b1, 32'd3, 32'h1000, 1, 0};
        vecs[2] = '{1'b0, 32'd0, 32'h0,    1'b1, 1'b1, 1'b0, 32'd0, 32'h0,    0, 1};
        vecs[3] = '{1'b0, 32'd0, 32'h0,    1'b1, 1'b0, 1'b0, 32'd0, 32'h0,    0, 0};

        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        sample();
        chk("reset_dut0", obs[0], '0);
        chk("reset_dut1", obs[1], '0);
        advance();
        rst_n = 1'b1;

        // single push through the stored path
        for (int i = 0; i < 4; i++) begin
            in_valid[0]  = vecs[i].in_valid;
            in_ent[0]    = vecs[i].in_valid ? '{vecs[i].id, vecs[i].addr, 8'd0, 3'd0, 2'd0, 4'd0} : '0;
            out_ready[0] = vecs[i].out_ready;
            rsp[0]       = vecs[i].rsp;
            sample();
            chk($sformatf("vec%0d_valid", i), 128'(out0.valid), 128'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_id", i), 128'(out0.id), 128'(vecs[i].exp_id));
            chk($sformatf("vec%0d_addr", i), 128'(out0.addr), 128'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_level", i), 128'(level0), 128'(vecs[i].exp_level));
            chk($sformatf("vec%0d_outst", i), 128'(outst0), 128'(vecs[i].exp_outst));
            advance();
        end
        idle_inputs();

        // fill dut0 with the slave stalled, then drain in order across the pointer wrap
        for (int i = 0; i < 8; i++) begin
            in_valid[0] = 1'b1; in_ent[0] = mk(i, 32'h2000 + 32'(i * 64));
            sample(); advance();
        end
        in_valid[0] = 1'b0;
        sample();
        chk("full_level", 128'(level0), 128'd8);
        chk("full_ready", 128'(in0.ready), 128'd0);
        chk("full_af", 128'(af0), 128'd1);
        advance();
        out_ready[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rsp[0] = (mout[0] > 0);
            sample(); advance();
        end
        chk("drained_level", 128'(level0), 128'd0);
        idle_inputs();

        // bypass: same-cycle pass, then stall and hold
        in_valid[1] = 1'b1; in_ent[1] = mk(5, 32'h5000); out_ready[1] = 1'b1;
        sample();
        chk("byp_valid", 128'(out1.valid), 128'd1);
        chk("byp_id", 128'(out1.id), 128'd5);
        chk("byp_level", 128'(level1), 128'd0);
        advance();
        in_ent[1] = mk(6, 32'h6000); out_ready[1] = 1'b0;
        sample(); advance();
        in_valid[1] = 1'b0; in_ent[1] = '0;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("byp_held_valid", 128'(out1.valid), 128'd1);
            chk("byp_held_id", 128'(out1.id), 128'd6);
            chk("byp_held_level", 128'(level1), 128'd1);
            advance();
        end
        out_ready[1] = 1'b1;
        sample(); advance();
        sample(); advance();
        idle_inputs();

        // limiter on dut0: four queued, only two issue until a completion
        for (int i = 0; i < 4; i++) begin
            in_valid[0] = 1'b1; in_ent[0] = mk(32'(10 + i), 32'h8000 + 32'(i * 16));
            sample(); advance();
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin sample(); advance(); end
        sample();
        chk("thr_outst", 128'(outst0), 128'd2);
        chk("thr_valid", 128'(out0.valid), 128'd0);
        chk("thr_level", 128'(level0), 128'd2);
        rsp[0] = 1'b1;
        advance();
        rsp[0] = 1'b0;
        sample();
        chk("thr_release_valid", 128'(out0.valid), 128'd1);
        chk("thr_release_id", 128'(out0.id), 128'd12);
        advance();
        sample();
        chk("thr_after_outst", 128'(outst0), 128'd2);
        chk("thr_after_level", 128'(level0), 128'd1);
        advance();

        // asynchronous reset mid-stream, with a bypass request waiting on dut1
        in_valid[1] = 1'b1; in_ent[1] = mk(7, 32'h7000); out_ready[1] = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_dut0", obs[0], '0);
        chk("async_rst_dut1", obs[1], '0);
        @(posedge clk); #1;
        idle_inputs();
        sample(); advance();
        rst_n = 1'b1;
        in_valid[0] = 1'b1; in_ent[0] = mk(9, 32'h9000); out_ready[0] = 1'b1;
        sample(); advance();
        in_valid[0] = 1'b0;
        sample();
        chk("post_rst_id", 128'(out0.id), 128'd9);
        chk("post_rst_level", 128'(level0), 128'd1);
        advance();
        idle_inputs();
        sample(); advance();
        rsp[0] = 1'b1;
        sample(); advance();
        rsp[0] = 1'b0;

        // completion with nothing outstanding
        rsp[0] = 1'b1; rsp[1] = 1'b1;
        sample(); advance();
        rsp[0] = 1'b0; rsp[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("uf_dut0", 128'(uf0), 128'd1);
            chk("uf_outst0", 128'(outst0), 128'd0);
            chk("uf_dut1", 128'(uf1), 128'd1);
            advance();
        end

        // randomized traffic with an AXI-compliant upstream
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(in_valid[k] && !macc[k])) begin
                    in_valid[k] = ($urandom_range(0, 99) < 55);
                    in_ent[k]   = rand_ent();
                end
                out_ready[k] = ($urandom_range(0, 99) < 60);
                rsp[k]       = ($urandom_range(0, 99) < 30);
            end
            sample(); advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
